// File: rtl/oh_rrarb3_pkg.sv
// Shared definitions for the three-requester round-robin arbiter:
// requester count, pointer encodings and the rotating priority picker.
package oh_rrarb3_pkg;

  localparam int NREQ = 3;

  // Priority pointer encodings: the requester named here is scanned first.
  localparam logic [1:0] PTR_0 = 2'd0;
  localparam logic [1:0] PTR_1 = 2'd1;
  localparam logic [1:0] PTR_2 = 2'd2;

  // One-hot of the first valid requester scanning p, p+1, p+2 (mod 3).
  function automatic logic [2:0] rr_pick(input logic [2:0] v, input logic [1:0] p);
    logic [2:0] g;
    g = 3'b000;
    case (p)
      PTR_0:   g = v[0] ? 3'b001 : v[1] ? 3'b010 : v[2] ? 3'b100 : 3'b000;
      PTR_1:   g = v[1] ? 3'b010 : v[2] ? 3'b100 : v[0] ? 3'b001 : 3'b000;
      default: g = v[2] ? 3'b100 : v[0] ? 3'b001 : v[1] ? 3'b010 : 3'b000;
    endcase
    return g;
  endfunction

  // Index of a one-hot requester vector (zero maps to requester 0).
  function automatic logic [1:0] onehot_idx(input logic [2:0] g);
    return g[2] ? PTR_2 : g[1] ? PTR_1 : PTR_0;
  endfunction

  // Next pointer position, wrapping 2 -> 0.
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == PTR_2) ? PTR_0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/oh_rrarb3_mux.sv
// One-hot 3-way AND-OR mux: z = (s0&d0)|(s1&d1)|(s2&d2), one term per bit.
module oh_rrarb3_mux #(
  parameter int DW = 32
) (
  input  logic [2:0]      sel,
  input  logic [3*DW-1:0] data,
  output logic [DW-1:0]   z
);

  assign z = ({DW{sel[0]}} & data[0*DW +: DW])
           | ({DW{sel[1]}} & data[1*DW +: DW])
           | ({DW{sel[2]}} & data[2*DW +: DW]);

endmodule

// File: rtl/oh_rrarb3.sv
// Three-requester round-robin arbiter feeding a single-entry output register.
// Optional burst mode (macro OH_RRARB3_BURST_EN) lets a winner keep top
// priority for up to BURST consecutive beats.
//
// Handshake: a beat moves across an interface on a rising edge where both
// valid and ready are high. req_ready is one-hot (or zero), depends only on
// req_valid, the pointer, out_valid and out_ready (never on req_data), and
// requesters hold data stable while valid and not ready. The output register
// may be drained and reloaded in the same cycle.
module oh_rrarb3
  import oh_rrarb3_pkg::*;
#(
  parameter int DW    = 32,
  parameter int BURST = 4
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic [2:0]      req_valid,
  input  logic [3*DW-1:0] req_data,
  output logic [2:0]      req_ready,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  input  logic            out_ready,
  output logic [2:0]      grant
);

  logic [1:0]    ptr;
  logic [1:0]    ptr_nxt;
  logic [2:0]    winner;
  logic [1:0]    win_idx;
  logic          load;
  logic [DW-1:0] mux_data;

  // The reset term keeps req_ready low while the block is held in reset, so
  // no requester believes it transferred into a register that is cleared.
  assign load      = nreset & (~out_valid | out_ready) & (|req_valid);
  assign winner    = rr_pick(req_valid, ptr);
  assign win_idx   = onehot_idx(winner);
  assign req_ready = load ? winner : 3'b000;

  oh_rrarb3_mux #(.DW(DW)) u_mux (
    .sel  (winner),
    .data (req_data),
    .z    (mux_data)
  );

  // Output register: load on a winning beat, empty on a drain with no request.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      grant     <= 3'b000;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= mux_data;
      grant     <= winner;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      grant     <= 3'b000;
    end
  end

`ifdef OH_RRARB3_BURST_EN
  localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [CW-1:0] cnt_now;
  logic          hold;
  logic          owner_valid;

  // Pointer/count next state: a nonzero count means the pointer is being held
  // on its current requester; that hold ends on the last allowed beat, when
  // the owner loses to someone else, or when the owner drops valid while idle.
  always_comb begin
    ptr_nxt     = ptr;
    cnt_nxt     = cnt;
    cnt_now     = (win_idx == ptr) ? cnt : '0;
    hold        = (int'(cnt_now) < BURST - 1);
    owner_valid = |(req_valid & rr_pick(3'b111, ptr));
    if (load) begin
      if (hold) begin
        ptr_nxt = win_idx;
        cnt_nxt = cnt_now + CW'(1);
      end else begin
        ptr_nxt = ptr_inc(win_idx);
        cnt_nxt = '0;
      end
    end else if ((cnt != '0) && !owner_valid) begin
      ptr_nxt = ptr_inc(ptr);
      cnt_nxt = '0;
    end
  end

  // Pointer and burst count registers.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ptr <= PTR_0;
      cnt <= '0;
    end else begin
      ptr <= ptr_nxt;
      cnt <= cnt_nxt;
    end
  end
`else
  // Plain round-robin: the requester after the winner becomes highest priority.
  always_comb begin
    ptr_nxt = ptr;
    if (load) ptr_nxt = ptr_inc(win_idx);
  end

  // Pointer register.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) ptr <= PTR_0;
    else         ptr <= ptr_nxt;
  end
`endif

endmodule

// File: tb/tb_oh_rrarb3.sv
// Directed bench for oh_rrarb3 with hand-computed expected grants and words.
module tb_oh_rrarb3;

  localparam int DW = 32;

  logic          clk;
  logic          nreset;
  logic [2:0]    req_valid;
  logic [3*DW-1:0] req_data;
  logic [2:0]    req_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic [2:0]    grant;

  logic [DW-1:0] d [3];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] held;
  int            n_checks;
  int            n_fail;

  assign req_data = {d[2], d[1], d[0]};

  oh_rrarb3 #(.DW(DW), .BURST(4)) dut (
    .clk       (clk),
    .nreset    (nreset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .grant     (grant)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] word_of(input logic [2:0] g);
    logic [DW-1:0] w;
    w = '0;
    if (g[0]) w = d[0];
    if (g[1]) w = d[1];
    if (g[2]) w = d[2];
    return w;
  endfunction

  // Drive one cycle; called #1 after a rising edge, returns #1 after the next.
  task automatic step(input string tag, input logic [2:0] rv, input logic ordy,
                      input logic [2:0] e_rdy, input logic e_ov, input logic [2:0] e_gnt);
    req_valid = rv;
    out_ready = ordy;
    #1;
    check({tag, "/req_ready"}, 32'(req_ready), 32'(e_rdy));
    if (e_rdy != 3'b000) exp_q.push_back(word_of(e_rdy));
    @(posedge clk);
    #1;
    if (e_rdy != 3'b000 && exp_q.size() > 0) held = exp_q.pop_front();
    check({tag, "/out_valid"}, 32'(out_valid), 32'(e_ov));
    check({tag, "/grant"}, 32'(grant), 32'(e_gnt));
    check({tag, "/out_data"}, out_data, held);
  endtask

  // Assert reset mid-cycle and check that everything clears at once.
  task automatic async_reset(input string tag);
    nreset = 1'b0;
    #1;
    check({tag, "/out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "/grant"}, 32'(grant), 32'd0);
    check({tag, "/out_data"}, out_data, 32'd0);
    check({tag, "/req_ready"}, 32'(req_ready), 32'd0);
    held = '0;
    exp_q.delete();
    #2;
    nreset = 1'b1;
  endtask

  logic [2:0] rr_seq [3];

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    held      = '0;
    nreset    = 1'b0;
    req_valid = 3'b111;
    out_ready = 1'b1;
    d[0] = 32'hA0;
    d[1] = 32'hA1;
    d[2] = 32'hA2;
    rr_seq[0] = 3'b001;
    rr_seq[1] = 3'b010;
    rr_seq[2] = 3'b100;

    // Reset held with all requesters valid
    repeat (2) @(posedge clk);
    #1;
    check("rst/req_ready", 32'(req_ready), 32'd0);
    check("rst/out_valid", 32'(out_valid), 32'd0);
    check("rst/grant", 32'(grant), 32'd0);
    check("rst/out_data", out_data, 32'd0);
    nreset = 1'b1;

`ifdef OH_RRARB3_BURST_EN
    // Burst of four per requester with all valid
    for (int i = 0; i < 12; i++) begin
      logic [2:0] e;
      e = 3'b001 << (i / 4);
      step("burst", 3'b111, 1'b1, e, 1'b1, e);
    end
    // Two beats into requester 0's burst, then reset mid-burst
    step("pre_rst", 3'b111, 1'b1, 3'b001, 1'b1, 3'b001);
    step("pre_rst", 3'b111, 1'b1, 3'b001, 1'b1, 3'b001);
    async_reset("burst_rst");
    for (int i = 0; i < 4; i++) step("post_rst", 3'b111, 1'b1, 3'b001, 1'b1, 3'b001);
    step("post_rst_next", 3'b111, 1'b1, 3'b010, 1'b1, 3'b010);
`else
    // First grant then fairness: 0,1,2,0,1,2
    for (int i = 0; i < 6; i++) step("fair", 3'b111, 1'b1, rr_seq[i % 3], 1'b1, rr_seq[i % 3]);
    // Backpressure: register frozen on requester 2's word
    for (int i = 0; i < 3; i++) step("bp", 3'b111, 1'b0, 3'b000, 1'b1, 3'b100);
    step("bp_release", 3'b111, 1'b1, 3'b001, 1'b1, 3'b001);
    // ptr=1 -> requester 1 wins, ptr becomes 2
    step("to_ptr2", 3'b010, 1'b1, 3'b010, 1'b1, 3'b010);
    // ptr=2 with only 0 and 1 valid: wraps to 0
    step("wrap", 3'b011, 1'b1, 3'b001, 1'b1, 3'b001);
    step("skip", 3'b010, 1'b1, 3'b010, 1'b1, 3'b010);
    // Idle drain then prove pointer stayed at 2
    step("drain", 3'b000, 1'b1, 3'b000, 1'b0, 3'b000);
    step("ptr_hold", 3'b111, 1'b1, 3'b100, 1'b1, 3'b100);
    step("drain2", 3'b000, 1'b1, 3'b000, 1'b0, 3'b000);
    // Empty register loads even with out_ready low
    step("empty_load", 3'b010, 1'b0, 3'b010, 1'b1, 3'b010);
    // Single requesters with distinct bit patterns
    d[0] = 32'h5A5A5A5A;
    d[1] = 32'hFFFF0000;
    d[2] = 32'h0000FFFF;
    step("single2", 3'b100, 1'b1, 3'b100, 1'b1, 3'b100);
    step("single1", 3'b010, 1'b1, 3'b010, 1'b1, 3'b010);
    step("single0", 3'b001, 1'b1, 3'b001, 1'b1, 3'b001);
    step("stall", 3'b111, 1'b0, 3'b000, 1'b1, 3'b001);
    // Reset with a word held: discarded, pointer back to 0
    async_reset("mid_rst");
    step("after_rst", 3'b111, 1'b1, 3'b001, 1'b1, 3'b001);
    step("after_rst2", 3'b111, 1'b1, 3'b010, 1'b1, 3'b010);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/oh_rrarb3.md
Name: oh_rrarb3

Overview:
- Three-requester round-robin arbiter that shares one output channel.
- Produces a one-hot grant that steers a per-bit 3-way AND-OR mux: z = (g0&d0)|(g1&d1)|(g2&d2).
- The selected word goes into a single-entry output register with valid/ready handshake.
- Sits in front of shared resources such as a bus, memory port or serializer fed by three agents.

Parameters:
- DW, 32, data width per requester.
- BURST, 4, maximum consecutive beats one requester may hold the grant (used only with the optional feature).

Ports:
- clk  in  1  clock, all state on rising edge
- nreset  in  1  asynchronous active-low reset
- req_valid  in  3  per-requester valid
- req_data  in  3*DW  packed data, requester i at [i*DW +: DW]
- req_ready  out  3  per-requester accept, one-hot or zero
- out_valid  out  1  output register holds valid data
- out_data  out  DW  output register contents
- out_ready  in  1  downstream accept
- grant  out  3  registered one-hot of the requester whose data sits in out_data; zero when empty

Behaviour:
- Reset (nreset low, async): out_valid=0, out_data=0, grant=0, priority pointer ptr=0 (requester 0 highest), burst count=0.
- load = (~out_valid | out_ready) & (|req_valid).
- Winner selection: first valid requester scanning ptr, ptr+1, ptr+2 (mod 3).
- Winner mux: winner one-hot AND-OR mux over req_data.
- req_ready = winner one-hot when load, else 0.
  - Combinational from req_valid, ptr, out_valid and out_ready.
  - Never depends on req_data.
- Transfer on requester i: req_valid[i] & req_ready[i].
- On load, next cycle:
  - out_valid=1, out_data=muxed word, grant=winner.
  - ptr = (winner+1) mod 3; wrap 2->0.
- Latency: 1 cycle from accepted request to out_valid.
- Throughput: one beat per cycle. A simultaneous drain (out_valid&out_ready) and load in the same cycle is legal; the register is overwritten with no bubble.
- Drain with no request: out_valid=0 and grant=0 next cycle. out_data holds its last value; ptr unchanged.
- out_valid & ~out_ready: register, grant and ptr hold; req_ready=0.
- Single requester valid: always wins regardless of ptr.
- All three valid continuously with out_ready=1: grant sequence 0,1,2,0,... from reset.
- Requester dropping valid without a transfer is permitted and never granted. Requesters must hold data stable while valid and not ready.
- Mid-operation nreset assertion: the held word is discarded and all state returns to reset values immediately.

Optional Feature:
- Macro OH_RRARB3_BURST_EN.
- Defined:
  - After a transfer from requester i, ptr stays at i, so i remains highest priority, while req_valid[i] stays high and burst count < BURST-1.
  - Burst count increments per transfer from the same requester.
  - When the count reaches BURST-1, or i drops valid, or another requester wins: ptr=(i+1) mod 3 and count=0.
  - Count width is clog2(BURST).
  - BURST=1 behaves identically to plain round-robin.
- Undefined: no counter logic; pure round-robin as above; BURST ignored.

Decomposition:
- Shared package oh_rrarb3_pkg holds:
  - requester-count localparam NREQ=3
  - ptr encoding constants
  - a function rotating one-hot priority selection
- One sub-module, oh_rrarb3_mux: parameterized DW, one-hot 3-way AND-OR mux, purely combinational, one AND-OR term per bit.
- Top-level oh_rrarb3 holds:
  - the arbitration and pointer logic
  - the burst counter
  - the output register

Test Plan:
- Reset: hold nreset low with req_valid=3'b111 -> req_ready=0, out_valid=0, grant=0. On release with out_ready=1 -> first grant=3'b001, ptr=1.
- Fairness: req_valid=3'b111, out_ready=1, data i=32'hA0+i, 6 cycles -> out_data A0,A1,A2,A0,A1,A2 with grant 001,010,100 repeating, one beat per cycle.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_data and grant frozen, req_ready=0. Release -> next word loads in the same cycle as the drain.
- Wrap and skip: ptr=2, req_valid=3'b011 -> requester 0 wins, ptr becomes 1. Then only req_valid[1] -> requester 1 wins.
- Idle drain: single transfer then req_valid=0 -> out_valid falls after one accept cycle, ptr unchanged.
- With OH_RRARB3_BURST_EN and BURST=4, all requesters valid -> grants 0,0,0,0,1,1,1,1,2... Reset asserted mid-burst -> count=0, ptr=0.
